// File: rtl/pdp8_pin_bridge.sv
// Bridge between the PDP-8 multiplexed 8-bit pin bus and a req/ack SRAM port plus an IO port.
// Decodes address halves, nibble writes and IO select; returns read data one nibble at a time.
module pdp8_pin_bridge #(
  parameter int AW = 12,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    cpu_out,
  output logic [3:0]    cpu_din,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          io_mode,
  output logic [4:0]    io_sel,
  output logic          io_wr,
  output logic [DW-1:0] io_wdata,
  input  logic [DW-1:0] io_rdata,
  output logic          busy,
  output logic          overrun
);

  typedef enum logic {IDLE, REQ} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wbuf_q;
  logic [DW-1:0] rdBuf_q, rdBuf_d;
  logic [4:0]    ioSel_q;
  logic          ioMode_q;
  logic          ioWr_q;
  logic [DW-1:0] ioWdata_q;
  logic          overrun_q, overrun_d;
  logic          memWe_q, memWe_d;
  logic [AW-1:0] memAddr_q, memAddr_d;
  logic [DW-1:0] memWdata_q, memWdata_d;
  logic          pendValid_q, pendValid_d;
  logic          pendWe_q, pendWe_d;
  logic [AW-1:0] pendAddr_q, pendAddr_d;
  logic [DW-1:0] pendWdata_q, pendWdata_d;

  logic          isAddrHi, isAddrLo, isIoSel, isNibWr, isCommit;
  logic [DW-1:0] commitWord;
  logic          newReq, newWe;
  logic [AW-1:0] newAddr;
  logic          toSlot;
  logic [DW-1:0] dinSrc;

  assign isAddrHi   = (cpu_out[7:6] == 2'b11);
  assign isAddrLo   = (cpu_out[7:6] == 2'b10);
  assign isIoSel    = (cpu_out[7:5] == 3'b011);
  assign isNibWr    = !cpu_out[7] && (cpu_out[6:5] != 2'b11) && cpu_out[4];
  assign isCommit   = isNibWr && (cpu_out[6:5] == 2'b10);
  assign commitWord = {wbuf_q[11:4], cpu_out[3:0]};

  // A low-address write both latches the address and launches a read of the new address.
  assign newReq  = isAddrLo || (isCommit && !ioMode_q);
  assign newWe   = isCommit;
  assign newAddr = isAddrLo ? {addr_q[11:6], cpu_out[5:0]} : addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wbuf_q    <= '0;
      ioMode_q  <= 1'b0;
      ioSel_q   <= '0;
      ioWr_q    <= 1'b0;
      ioWdata_q <= '0;
    end else begin
      ioWr_q <= isCommit && ioMode_q;
      if (isAddrHi) begin
        addr_q[11:6] <= cpu_out[5:0];
        ioMode_q     <= 1'b0;
      end
      if (isAddrLo) begin
        addr_q[5:0] <= cpu_out[5:0];
        ioMode_q    <= 1'b0;
      end
      if (isIoSel) begin
        ioMode_q <= 1'b1;
        ioSel_q  <= cpu_out[4:0];
      end
      if (isNibWr) begin
        case (cpu_out[6:5])
          2'b00:   wbuf_q[11:8] <= cpu_out[3:0];
          2'b01:   wbuf_q[7:4]  <= cpu_out[3:0];
          default: wbuf_q[3:0]  <= cpu_out[3:0];
        endcase
      end
      if (isCommit && ioMode_q) ioWdata_q <= commitWord;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rdBuf_q     <= '0;
      overrun_q   <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      pendValid_q <= 1'b0;
      pendWe_q    <= 1'b0;
      pendAddr_q  <= '0;
      pendWdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rdBuf_q     <= rdBuf_d;
      overrun_q   <= overrun_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      pendValid_q <= pendValid_d;
      pendWe_q    <= pendWe_d;
      pendAddr_q  <= pendAddr_d;
      pendWdata_q <= pendWdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rdBuf_d     = rdBuf_q;
    overrun_d   = overrun_q;
    memWe_d     = memWe_q;
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    pendValid_d = pendValid_q;
    pendWe_d    = pendWe_q;
    pendAddr_d  = pendAddr_q;
    pendWdata_d = pendWdata_q;
    toSlot      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (newReq) begin
          state_d    = REQ;
          memWe_d    = newWe;
          memAddr_d  = newAddr;
          memWdata_d = commitWord;
        end
      end
      REQ: begin
        if (mem_ack) begin
          rdBuf_d = memWe_q ? memWdata_q : mem_rdata;
          // The slot issues first; a request arriving on the same edge takes its place.
          if (pendValid_q) begin
            memWe_d     = pendWe_q;
            memAddr_d   = pendAddr_q;
            memWdata_d  = pendWdata_q;
            pendValid_d = 1'b0;
            toSlot      = newReq;
          end else if (newReq) begin
            memWe_d    = newWe;
            memAddr_d  = newAddr;
            memWdata_d = commitWord;
          end else begin
            state_d = IDLE;
          end
        end else begin
          toSlot = newReq;
        end
      end
    endcase
    // A held read is always superseded; a held write wins and a second write is lost.
    if (toSlot) begin
      if (!pendValid_d || !pendWe_d) begin
        pendValid_d = 1'b1;
        pendWe_d    = newWe;
        pendAddr_d  = newAddr;
        pendWdata_d = commitWord;
      end else if (newWe) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    dinSrc  = ioMode_q ? io_rdata : rdBuf_q;
    cpu_din = 4'h0;
    if (!cpu_out[7]) begin
      case (cpu_out[6:5])
        2'b00:   cpu_din = dinSrc[11:8];
        2'b01:   cpu_din = dinSrc[7:4];
        2'b10:   cpu_din = dinSrc[3:0];
        default: cpu_din = 4'h0;
      endcase
    end
  end

  assign mem_req   = (state_q == REQ);
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign io_mode   = ioMode_q;
  assign io_sel    = ioSel_q;
  assign io_wr     = ioWr_q;
  assign io_wdata  = ioWdata_q;
  assign busy      = (state_q != IDLE) || pendValid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pdp8_pin_bridge.sv
// Self-checking bench for pdp8_pin_bridge: nibble-readback vector table plus
// scoreboarded SRAM/IO transactions for the multi-cycle sequences.
module tb_pdp8_pin_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cpu_out;
  logic [3:0]  cpu_din;
  logic        mem_req, mem_we, mem_ack;
  logic [11:0] mem_addr, mem_wdata, mem_rdata;
  logic        io_mode, io_wr, busy, overrun;
  logic [4:0]  io_sel;
  logic [11:0] io_wdata, io_rdata;

  typedef struct {
    logic [7:0]  cpuOut;
    logic [11:0] ioRdata;
    logic [3:0]  expDin;
  } vec_t;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [11:0] wdata;
  } req_t;

  vec_t        vecs [12];
  req_t        expQ [$];
  logic [11:0] ioQ  [$];
  int          checks = 0;
  int          errors = 0;

  pdp8_pin_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_out   (cpu_out),
    .cpu_din   (cpu_din),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .io_mode   (io_mode),
    .io_sel    (io_sel),
    .io_wr     (io_wr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present one pin-bus value for exactly one sampling edge.
  task automatic applyStimulus(input logic [7:0] v);
    cpu_out = v;
    tick();
    cpu_out = 8'h00;
  endtask

  // Pin values are applied only between edges so the state-changing codes are never sampled.
  task automatic runTable(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cpu_out  = vecs[i].cpuOut;
      io_rdata = vecs[i].ioRdata;
      #1;
      checkOutput($sformatf("din_vec%0d", i), {28'h0, cpu_din}, {28'h0, vecs[i].expDin});
      cpu_out  = 8'h00;
      io_rdata = 12'h000;
      tick();
    end
  endtask

  task automatic serviceReq(input int delay, input logic [11:0] rdata);
    req_t exp;
    int   waitCyc = 0;
    while (!mem_req && waitCyc < 50) begin
      tick();
      waitCyc++;
    end
    if (!mem_req) begin
      checkOutput("req_timeout", 32'd0, 32'd1);
    end else if (expQ.size() == 0) begin
      checkOutput("unexpected_req", {20'h0, mem_addr}, 32'hFFFF_FFFF);
    end else begin
      exp = expQ.pop_front();
      checkOutput("mem_we", {31'h0, mem_we}, {31'h0, exp.we});
      checkOutput("mem_addr", {20'h0, mem_addr}, {20'h0, exp.addr});
      if (exp.we) checkOutput("mem_wdata", {20'h0, mem_wdata}, {20'h0, exp.wdata});
      for (int i = 0; i < delay; i++) begin
        tick();
        checkOutput("req_hold", {31'h0, mem_req}, 32'd1);
      end
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 12'h000;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ioWrCount;
    logic [11:0] ioExp;

    vecs[0]  = '{8'h00, 12'h555, 4'hA};
    vecs[1]  = '{8'h20, 12'h555, 4'hB};
    vecs[2]  = '{8'h40, 12'h555, 4'hC};
    vecs[3]  = '{8'h60, 12'h555, 4'h0};
    vecs[4]  = '{8'h8F, 12'h555, 4'h0};
    vecs[5]  = '{8'h1F, 12'h555, 4'hA};
    vecs[6]  = '{8'h3F, 12'h555, 4'hB};
    vecs[7]  = '{8'hE0, 12'h555, 4'h0};
    vecs[8]  = '{8'h00, 12'h9D2, 4'h9};
    vecs[9]  = '{8'h20, 12'h9D2, 4'hD};
    vecs[10] = '{8'h40, 12'h9D2, 4'h2};
    vecs[11] = '{8'h60, 12'h9D2, 4'h0};

    rst = 1'b1; cpu_out = 8'h00; mem_ack = 1'b0; mem_rdata = 12'h000; io_rdata = 12'h000;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_mem_req", {31'h0, mem_req}, 32'd0);
    checkOutput("rst_busy", {31'h0, busy}, 32'd0);
    checkOutput("rst_io_mode", {31'h0, io_mode}, 32'd0);
    checkOutput("rst_overrun", {31'h0, overrun}, 32'd0);
    checkOutput("rst_io_wr", {31'h0, io_wr}, 32'd0);
    checkOutput("rst_cpu_din", {28'h0, cpu_din}, 32'd0);

    // Read of 0x14A, acked after three wait cycles.
    applyStimulus(8'hC5);
    expQ.push_back('{1'b0, 12'h14A, 12'h000});
    applyStimulus(8'h8A);
    checkOutput("read_latency", {31'h0, mem_req}, 32'd1);
    checkOutput("read_busy", {31'h0, busy}, 32'd1);
    serviceReq(3, 12'hABC);
    checkOutput("read_done_req", {31'h0, mem_req}, 32'd0);
    checkOutput("read_done_busy", {31'h0, busy}, 32'd0);
    runTable(0, 7);

    // Setting the low address half also launches a read of 0x001.
    applyStimulus(8'hC0);
    expQ.push_back('{1'b0, 12'h001, 12'h000});
    applyStimulus(8'h81);
    serviceReq(0, 12'h777);
    applyStimulus(8'h1F);
    applyStimulus(8'h33);
    expQ.push_back('{1'b1, 12'h001, 12'hF39});
    applyStimulus(8'h59);
    serviceReq(1, 12'h000);
    cpu_out = 8'h00; #1; checkOutput("wr_rb_hi", {28'h0, cpu_din}, 32'hF);
    cpu_out = 8'h20; #1; checkOutput("wr_rb_mid", {28'h0, cpu_din}, 32'h3);
    cpu_out = 8'h40; #1; checkOutput("wr_rb_lo", {28'h0, cpu_din}, 32'h9);
    cpu_out = 8'h00;
    tick();

    // IO write of 0x123 to device 0x12.
    applyStimulus(8'h72);
    checkOutput("io_mode_set", {31'h0, io_mode}, 32'd1);
    checkOutput("io_sel", {27'h0, io_sel}, 32'h12);
    applyStimulus(8'h11);
    applyStimulus(8'h32);
    ioQ.push_back(12'h123);
    applyStimulus(8'h53);
    ioWrCount = 0;
    for (int i = 0; i < 4; i++) begin
      if (io_wr) begin
        ioWrCount++;
        ioExp = (ioQ.size() != 0) ? ioQ.pop_front() : 12'hFFF;
        checkOutput("io_wdata", {20'h0, io_wdata}, {20'h0, ioExp});
      end
      checkOutput("io_no_mem_req", {31'h0, mem_req}, 32'd0);
      tick();
    end
    checkOutput("io_wr_pulses", ioWrCount, 32'd1);
    runTable(8, 11);

    // Three write commits with ack held low: one in flight, one pending, one dropped.
    applyStimulus(8'hC2);
    checkOutput("io_mode_clr", {31'h0, io_mode}, 32'd0);
    applyStimulus(8'h1A);
    applyStimulus(8'h3B);
    expQ.push_back('{1'b1, 12'h081, 12'hABC});
    applyStimulus(8'h5C);
    expQ.push_back('{1'b1, 12'h081, 12'hABD});
    applyStimulus(8'h5D);
    checkOutput("ovr_before", {31'h0, overrun}, 32'd0);
    applyStimulus(8'h5E);
    checkOutput("ovr_set", {31'h0, overrun}, 32'd1);
    checkOutput("ovr_busy", {31'h0, busy}, 32'd1);
    serviceReq(2, 12'h000);
    checkOutput("pend_issue", {31'h0, mem_req}, 32'd1);
    serviceReq(0, 12'h000);
    checkOutput("pend_done_req", {31'h0, mem_req}, 32'd0);
    checkOutput("pend_done_busy", {31'h0, busy}, 32'd0);
    checkOutput("ovr_sticky", {31'h0, overrun}, 32'd1);

    // Two reads queued behind a write; only the newer address survives.
    expQ.push_back('{1'b1, 12'h081, 12'hABF});
    applyStimulus(8'h5F);
    applyStimulus(8'hC1);
    applyStimulus(8'h80);
    applyStimulus(8'hC2);
    expQ.push_back('{1'b0, 12'h080, 12'h000});
    applyStimulus(8'h80);
    serviceReq(1, 12'h000);
    serviceReq(0, 12'h3C5);
    checkOutput("replace_done", {31'h0, mem_req}, 32'd0);
    cpu_out = 8'h00; #1; checkOutput("replace_rb", {28'h0, cpu_din}, 32'h3);
    cpu_out = 8'h00;
    tick();
    checkOutput("sb_empty", expQ.size(), 32'd0);

    // Reset in the middle of a read, then a stray ack while idle.
    applyStimulus(8'h80);
    applyStimulus(8'h72);
    checkOutput("mid_req", {31'h0, mem_req}, 32'd1);
    checkOutput("mid_io_mode", {31'h0, io_mode}, 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("rst_drop_req", {31'h0, mem_req}, 32'd0);
    tick();
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 12'hFFF;
    checkOutput("rst2_busy", {31'h0, busy}, 32'd0);
    checkOutput("rst2_io_mode", {31'h0, io_mode}, 32'd0);
    checkOutput("rst2_overrun", {31'h0, overrun}, 32'd0);
    checkOutput("rst2_cpu_din", {28'h0, cpu_din}, 32'd0);
    tick();
    mem_ack = 1'b0;
    mem_rdata = 12'h000;
    checkOutput("late_ack_req", {31'h0, mem_req}, 32'd0);
    cpu_out = 8'h00; #1; checkOutput("late_ack_hi", {28'h0, cpu_din}, 32'd0);
    cpu_out = 8'h40; #1; checkOutput("late_ack_lo", {28'h0, cpu_din}, 32'd0);
    cpu_out = 8'h00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
